// File: rtl/if_fetch_stage.sv
//------------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID register. Owns the fetch PC,
// keeps at most one instruction-memory request in flight (req/ack), parks one
// returned word in a skid register while the pipeline is stalled, and
// redirects on branch/flush. The in-flight request is always allowed to
// complete; after a redirect its data is silently dropped.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam int unsigned DATA_W = 32;

  // IDLE : no request, waiting for start_i
  // FETCH: request to fetch_pc_q outstanding
  // HOLD : output slot and skid register both full, no request
  // DROP : redirect arrived mid-request; finish it, discard the data
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10,
    S_DROP  = 2'b11
  } state_t;

  state_t              state_q;
  logic [31:0]         fetch_pc_q;
  logic [31:0]         redir_pc_q;
  logic [DATA_W-1:0]   skid_instr_q;
  logic [31:0]         skid_pc_q;

  logic                consume;
  logic                slot_free;
  logic [31:0]         redir_tgt;
  logic [31:0]         pc_seq;

  // Sequential PC with plain 32-bit wrap-around.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Word-align any address entering the PC.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

  // Offered word leaves this edge only if IF/ID is not held and not flushed.
  assign consume   = valid_o & ~stall_i & ~redirect_i;
  assign slot_free = ~valid_o | consume;
  assign redir_tgt = word_align(redirect_pc_i);
  assign pc_seq    = pc_inc(fetch_pc_q);

  // Memory interface is a pure decode of state; no input reaches it.
  // In DROP the fetch PC still holds the in-flight address.
  assign imem_req_o  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr_o = fetch_pc_q;

  // Fetch control, PC, skid buffer and registered IF/ID outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= word_align(RESET_PC);
      redir_pc_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_o      <= '0;
      pc_o         <= '0;
      valid_o      <= 1'b0;
    end else if (redirect_i) begin
      // Flush wins over stall and over returning data.
      valid_o <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack_i) begin
            // Request finished this edge: drop its data, restart at target.
            fetch_pc_q <= redir_tgt;
          end else begin
            // Request still in flight: remember target until it finishes.
            redir_pc_q <= redir_tgt;
            state_q    <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_ack_i) begin
            fetch_pc_q <= redir_tgt;
            state_q    <= start_i ? S_FETCH : S_IDLE;
          end else begin
            redir_pc_q <= redir_tgt;
          end
        end
        default: begin
          // IDLE or HOLD: nothing in flight, skid contents are discarded.
          fetch_pc_q <= redir_tgt;
          state_q    <= start_i ? S_FETCH : S_IDLE;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (consume) begin
            valid_o <= 1'b0;
          end
          if (start_i) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            fetch_pc_q <= pc_seq;
            if (slot_free) begin
              instr_o <= imem_data_i;
              pc_o    <= fetch_pc_q;
              valid_o <= 1'b1;
              state_q <= start_i ? S_FETCH : S_IDLE;
            end else begin
              // Output still occupied: park the word until IF/ID takes it.
              skid_instr_q <= imem_data_i;
              skid_pc_q    <= fetch_pc_q;
              state_q      <= S_HOLD;
            end
          end else if (consume) begin
            valid_o <= 1'b0;
          end
        end
        S_HOLD: begin
          // HOLD implies the skid register is full.
          if (consume) begin
            instr_o <= skid_instr_q;
            pc_o    <= skid_pc_q;
            valid_o <= 1'b1;
            state_q <= start_i ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          // S_DROP: wait for the abandoned request, then jump.
          if (consume) begin
            valid_o <= 1'b0;
          end
          if (imem_ack_i) begin
            fetch_pc_q <= redir_pc_q;
            state_q    <= start_i ? S_FETCH : S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps

module tb_if_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;

  logic        req_w;
  logic [31:0] addr_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;
  logic        valid_w;

  int checks = 0;
  int errors = 0;

  // Reference model: fetched-but-unconsumed words as a queue (front = offered)
  logic [31:0] m_qi[$];
  logic [31:0] m_qp[$];
  logic        m_req;
  logic        m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(req_w), .imem_addr_o(addr_w),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_o(instr_w), .pc_o(pc_w), .valid_o(valid_w)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #10_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    m_qi.delete();
    m_qp.delete();
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_pc   = rpc;
    m_tgt  = '0;
  endtask

  // One clock edge of the fetch rules, using the inputs currently driven.
  task automatic model_edge();
    logic        cons;
    logic [31:0] t;
    cons = (m_qp.size() != 0) && !stall_i && !redirect_i;
    if (cons) begin
      void'(m_qp.pop_front());
      void'(m_qi.pop_front());
    end
    t = {redirect_pc_i[31:2], 2'b00};
    if (redirect_i) begin
      m_qp.delete();
      m_qi.delete();
      if (m_req && !imem_ack_i) begin
        m_drop = 1'b1;
        m_tgt  = t;
      end else if (m_req && !m_drop) begin
        m_pc = t;
      end else begin
        m_pc   = t;
        m_drop = 1'b0;
        m_req  = start_i;
      end
    end else if (m_req && imem_ack_i) begin
      if (m_drop) begin
        m_drop = 1'b0;
        m_pc   = m_tgt;
        m_req  = start_i;
      end else begin
        m_qi.push_back(imem_data_i);
        m_qp.push_back(m_pc);
        m_pc  = m_pc + 32'd4;
        m_req = start_i && (m_qp.size() < 2);
      end
    end else if (!m_req) begin
      m_req = start_i && (m_qp.size() < 2);
    end
  endtask

  task automatic check_all();
    chk("req", 32'(imem_req_o), 32'(m_req));
    if (m_req) chk("addr", imem_addr_o, m_pc);
    chk("valid", 32'(valid_o), 32'(m_qp.size() != 0));
    if (m_qp.size() != 0) begin
      chk("pc", pc_o, m_qp[0]);
      chk("instr", instr_o, m_qi[0]);
    end
  endtask

  // Called at a negedge: drive inputs, advance one posedge, check at next negedge.
  task automatic cyc(input logic st, input logic sl, input logic rd,
                     input logic [31:0] rp, input logic ak);
    start_i       = st;
    stall_i       = sl;
    redirect_i    = rd;
    redirect_pc_i = rp;
    imem_ack_i    = ak;
    imem_data_i   = ak ? memf(m_pc) : $urandom;
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    logic        r_st, r_sl, r_rd, r_ak;
    logic [31:0] r_pc;

    rst_i = 1'b1;
    start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; imem_ack_i = 1'b0; imem_data_i = '0;
    model_reset(32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);

    // zero-wait streaming, plus wrap on the second instance
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("z_addr0", imem_addr_o, 32'h0);
    chk("wrap_req", 32'(req_w), 32'h1);
    chk("wrap_addr0", addr_w, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("z_addr1", imem_addr_o, 32'h4);
    chk("z_pc0", pc_o, 32'h0);
    chk("wrap_addr1", addr_w, 32'h0000_0000);
    chk("wrap_pc", pc_w, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(valid_w), 32'h1);
    chk("wrap_instr", instr_w, memf(32'h0));
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("z_addr2", imem_addr_o, 32'h8);
    chk("z_pc1", pc_o, 32'h4);

    // ack under stall goes to skid
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_req", 32'(imem_req_o), 32'h0);
    chk("hold_pc", pc_o, 32'h4);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_pc3", pc_o, 32'h4);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("skid_pc", pc_o, 32'h8);
    chk("resume_addr", imem_addr_o, 32'hC);

    // redirect during a multi-wait request
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_redir_addr", imem_addr_o, 32'h10);
    cyc(1'b1, 1'b0, 1'b1, 32'h103, 1'b0);
    chk("drop_valid", 32'(valid_o), 32'h0);
    chk("drop_addr", imem_addr_o, 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drop_addr2", imem_addr_o, 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("redir_valid", 32'(valid_o), 32'h0);

    // redirect coincident with ack, while stalled
    cyc(1'b1, 1'b0, 1'b1, 32'h1C, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_co_addr", imem_addr_o, 32'h20);
    cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    chk("co_valid", 32'(valid_o), 32'h0);
    chk("co_addr", imem_addr_o, 32'h200);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("co_pc", pc_o, 32'h200);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_st = ($urandom % 8) != 0;
      r_sl = ($urandom % 4) == 0;
      r_rd = ($urandom % 16) == 0;
      r_ak = ($urandom % 3) != 0;
      r_pc = $urandom;
      if (($urandom % 8) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      cyc(r_st, r_sl, r_rd, r_pc, r_ak);
    end

    // asynchronous reset in the middle of a request
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_rst_valid", 32'(valid_o), 32'h1);
    chk("pre_rst_req", 32'(imem_req_o), 32'h1);
    start_i = 1'b0; imem_ack_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req_o), 32'h0);
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    model_reset(32'h0);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("restart_addr", imem_addr_o, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("restart_pc", pc_o, 32'h0);
    chk("restart_instr", instr_o, memf(32'h0));
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
